// File: rtl/fifo_drain_ctrl.sv
// Read-side consumer for a synchronous FIFO: credit-based popping, 2-entry skid buffer
// on a valid/ready output stream, saturating good-read and underflow counters.
module fifo_drain_ctrl #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush_req,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  flush_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      rd_count,
  output logic [CNT_W-1:0]      uf_count
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                         state_q, state_d;
  logic [1:0]                     occ_q, occ_d, occ_after_pop;
  logic                           inflight_q;
  logic [1:0][FIFO_WIDTH-1:0]     buf_q, buf_d;
  logic [CNT_W-1:0]               rd_count_q, uf_count_q;
  logic                           pop, cap, uf_evt, drained;
  logic [2:0]                     credit;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = buf_q[0];
  assign pop      = m_valid && m_ready;
  assign cap      = inflight_q && !fifo_underflow;
  assign uf_evt   = inflight_q && fifo_underflow;
  assign drained  = fifo_empty && !inflight_q && (occ_q == 2'd0);
  assign rd_count = rd_count_q;
  assign uf_count = uf_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (flush_req)   state_d = StFlush;
        else if (enable) state_d = StRun;
      end
      StRun: begin
        if (flush_req)    state_d = StFlush;
        else if (!enable) state_d = StIdle;
      end
      StFlush: begin
        if (drained) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Credit: words already held plus the one in flight, minus the slot freed this cycle.
  always_comb begin
    credit     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = (state_q != StIdle) && !fifo_empty && (credit < 3'd2);
    flush_done = (state_q == StFlush) && drained;
    busy       = (state_q != StIdle) || (occ_q != 2'd0) || inflight_q;
  end

  // Shift the head out on pop, then write the captured word at the resulting tail.
  always_comb begin
    buf_d         = buf_q;
    occ_after_pop = occ_q - {1'b0, pop};
    if (pop) buf_d[0] = buf_q[1];
    if (cap) buf_d[occ_after_pop[0]] = fifo_data_out;
    occ_d = occ_after_pop + {1'b0, cap};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf_q      <= '0;
      rd_count_q <= '0;
      uf_count_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      buf_q      <= buf_d;
      if (cap && (rd_count_q != '1))    rd_count_q <= rd_count_q + CNT_W'(1);
      if (uf_evt && (uf_count_q != '1)) uf_count_q <= uf_count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a FIFO model with registered reads feeds the DUT, and a
// queue-based reference of the output stream, mode and counters checks it every cycle.
module tb_fifo_drain_ctrl;
  localparam int W  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0, flush_req = 1'b0, fifo_empty = 1'b1;
  logic          fifo_underflow = 1'b0, m_ready = 1'b0;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_rd_en, m_valid, flush_done, busy;
  logic [W-1:0]  m_data;
  logic [CW-1:0] rd_count, uf_count;

  fifo_drain_ctrl #(.FIFO_WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush_req(flush_req),
    .fifo_empty(fifo_empty), .fifo_data_out(fifo_data_out),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .flush_done(flush_done), .busy(busy),
    .rd_count(rd_count), .uf_count(uf_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           mode = 0;  // 0 idle, 1 run, 2 flush
  logic         inflight_m = 1'b0, uf_now = 1'b0, uf_force = 1'b0;
  logic [W-1:0] cur_word = '0;
  int           rd_exp = 0, uf_exp = 0, uf_pct = 0;
  int           cyc = 0, pop_n = 0, first_pop = 0, last_pop = 0, rd_pulses = 0, fd_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(W'(base + i));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // One clock: check at negedge, advance the reference at posedge, then drive the FIFO side.
  task automatic step();
    logic pop, exp_rd, exp_fd, rd_s, en_s, fr_s;
    int   occ;
    @(negedge clk);
    occ    = exp_q.size();
    pop    = (occ != 0) && m_ready;
    exp_rd = (mode != 0) && !fifo_empty && ((occ + int'(inflight_m) - int'(pop)) < 2);
    exp_fd = (mode == 2) && fifo_empty && !inflight_m && (occ == 0);
    check("rd_en", fifo_rd_en, exp_rd);
    check("m_valid", m_valid, occ != 0);
    if (occ != 0) check("m_data", m_data, exp_q[0]);
    check("flush_done", flush_done, exp_fd);
    check("busy", busy, (mode != 0) || (occ != 0) || inflight_m);
    check("rd_count", rd_count, rd_exp);
    check("uf_count", uf_count, uf_exp);
    check("occ_bound", occ <= 2, 1);
    if (pop) begin
      if (pop_n == 0) first_pop = cyc;
      last_pop = cyc;
      pop_n++;
    end
    if (fifo_rd_en) rd_pulses++;
    if (flush_done) fd_cyc = cyc;
    rd_s = fifo_rd_en; en_s = enable; fr_s = flush_req;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (inflight_m) begin
      if (uf_now) uf_exp = sat(uf_exp);
      else begin
        exp_q.push_back(cur_word);
        rd_exp = sat(rd_exp);
      end
    end
    case (mode)
      0:       if (fr_s) mode = 2; else if (en_s) mode = 1;
      1:       if (fr_s) mode = 2; else if (!en_s) mode = 0;
      default: if (exp_fd) mode = 0;
    endcase
    inflight_m = rd_s;
    cyc++;
    #1;
    flush_req      = 1'b0;
    uf_now         = 1'b0;
    fifo_underflow = 1'b0;
    if (inflight_m) begin
      if (uf_force || ($urandom_range(99) < uf_pct)) begin
        uf_now         = 1'b1;
        uf_force       = 1'b0;
        fifo_underflow = 1'b1;
        fifo_data_out  = W'($urandom);
      end else begin
        cur_word      = fifo_q.pop_front();
        fifo_data_out = cur_word;
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete(); fifo_q.delete();
    mode = 0; inflight_m = 1'b0; uf_now = 1'b0; uf_force = 1'b0;
    rd_exp = 0; uf_exp = 0;
    fifo_underflow = 1'b0; fifo_empty = 1'b1; flush_req = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset holds rd_en low even with a non-empty FIFO and enable high.
    load(8, 1);
    enable  = 1'b1;
    m_ready = 1'b1;
    #12;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_uf_count", uf_count, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming 1..8 with the sink always ready: back-to-back output.
    pop_n = 0;
    repeat (14) step();
    check("stream_pops", pop_n, 8);
    check("stream_back_to_back", last_pop - first_pop, 7);
    check("stream_rd_count", rd_count, 8);

    // Sink stalled: only two reads, head holds the first word.
    do_reset();
    load(8, 1);
    enable = 1'b1; m_ready = 1'b0; rd_pulses = 0;
    repeat (6) step();
    check("stall_rd_pulses", rd_pulses, 2);
    check("stall_head", m_data, 16'h0001);
    m_ready = 1'b1; pop_n = 0;
    repeat (14) step();
    check("stall_drain_pops", pop_n, 8);

    // Underflow on the first read discards it.
    do_reset();
    load(1, 16'hABCD);
    uf_force = 1'b1; enable = 1'b1; m_ready = 1'b1;
    repeat (3) step();
    check("uf_count_one", uf_count, 1);
    check("uf_rd_unchanged", rd_count, 0);
    check("uf_no_valid", m_valid, 0);
    repeat (4) step();

    // Flush from idle: five words out, done pulse right after the last pop.
    do_reset();
    load(5, 16'h0100);
    m_ready = 1'b1; flush_req = 1'b1; pop_n = 0; fd_cyc = -1;
    repeat (20) step();
    check("flush_pops", pop_n, 5);
    check("flush_done_timing", fd_cyc, last_pop + 1);
    check("flush_idle_busy", busy, 0);

    // Reset in the middle of a transfer drops everything at once.
    do_reset();
    load(6, 16'h0200);
    enable = 1'b1; m_ready = 1'b0;
    repeat (3) step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_rd_count", rd_count, 0);
    check("mid_rst_uf_count", uf_count, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    do_reset();
    repeat (3) step();
    check("post_rst_no_capture", rd_count, 0);

    // Randomized traffic, underflows, enable toggles and flushes; counters saturate.
    do_reset();
    uf_pct = 12;
    repeat (1500) begin
      if ($urandom_range(19) == 0) enable = ~enable;
      if ($urandom_range(59) == 0) flush_req = 1'b1;
      m_ready = ($urandom_range(9) < 7);
      if ((fifo_q.size() < 4) && ($urandom_range(2) == 0)) begin
        fifo_q.push_back(W'($urandom));
        fifo_empty = 1'b0;
      end
      step();
    end
    check("rand_rd_sat", rd_count, rd_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
